alu_arbiter: RTL

//   Shares the single combinational ALU between N_REQ requesters, e.g. the main

---
 rtl/alu_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between N_REQ valid/ready requesters,
// one operation in flight. Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 2
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_srcA,
  input  logic [N_REQ*WIDTH-1:0] req_srcB_reg,
  input  logic [N_REQ*WIDTH-1:0] req_srcB_imm,
  input  logic [N_REQ*3-1:0]     req_ctrl,
  input  logic [N_REQ-1:0]       req_alusrc,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_zero,
  output logic [WIDTH-1:0]       alu_srcA,
  output logic [WIDTH-1:0]       alu_srcB_reg,
  output logic [WIDTH-1:0]       alu_srcB_imm,
  output logic [2:0]             alu_ctrl,
  output logic                   alu_src,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_zero
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  logic [GW-1:0]     grant_r;
  logic [GW-1:0]     rr_ptr_s;
  logic [GW-1:0]     pick_s;
  logic [GW-1:0]     idx_s;
  logic              found_s;
  logic [WIDTH-1:0]  srcA_r;
  logic [WIDTH-1:0]  srcB_reg_r;
  logic [WIDTH-1:0]  srcB_imm_r;
  logic [2:0]        ctrl_r;
  logic              alusrc_r;
  logic [WIDTH-1:0]  result_r;
  logic              zero_r;
  logic [N_REQ-1:0]  rsp_valid_r;

  // Search for the first valid requester at or after the pointer, wrapping to 0.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_s   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = GW'((int'(rr_ptr_s) + k) % N_REQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign rr_ptr_s = '0;
`else
  logic [GW-1:0] rr_ptr_r;
  logic [GW-1:0] grant_next_s;

  assign grant_next_s = GW'((int'(grant_r) + 1) % N_REQ);

  // Move the pointer past the owner once its response has been consumed.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rr_ptr_r <= '0;
    end else if (state_r == RESP && rsp_ready[grant_r]) begin
      rr_ptr_r <= grant_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign rr_ptr_s = rr_ptr_r;
`endif

  // Grant strobe is combinational in IDLE and forced low while reset is held.
  always_comb begin
    req_ready = '0;
    if (nreset && (state_r == IDLE) && found_s) begin
      req_ready[pick_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Operation sequencer: latch operands, capture ALU result, hold response.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r     <= IDLE;
      grant_r     <= '0;
      srcA_r      <= '0;
      srcB_reg_r  <= '0;
      srcB_imm_r  <= '0;
      ctrl_r      <= 3'd0;
      alusrc_r    <= 1'b0;
      result_r    <= '0;
      zero_r      <= 1'b0;
      rsp_valid_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant_r    <= pick_s;
            srcA_r     <= req_srcA[int'(pick_s)*WIDTH +: WIDTH];
            srcB_reg_r <= req_srcB_reg[int'(pick_s)*WIDTH +: WIDTH];
            srcB_imm_r <= req_srcB_imm[int'(pick_s)*WIDTH +: WIDTH];
            ctrl_r     <= req_ctrl[int'(pick_s)*3 +: 3];
            alusrc_r   <= req_alusrc[pick_s];
            state_r    <= EXEC;
          end else begin
            state_r    <= IDLE;
          end
        end
        EXEC: begin
          result_r    <= alu_result;
          zero_r      <= alu_zero;
          rsp_valid_r <= N_REQ'(1) << grant_r;
          state_r     <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant_r]) begin
            rsp_valid_r <= '0;
            state_r     <= IDLE;
          end else begin
            state_r     <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= '0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_r;
  assign rsp_result   = result_r;
  assign rsp_zero     = zero_r;
  assign alu_srcA     = srcA_r;
  assign alu_srcB_reg = srcB_reg_r;
  assign alu_srcB_imm = srcB_imm_r;
  assign alu_ctrl     = ctrl_r;
  assign alu_src      = alusrc_r;

endmodule
